key_entry_buffer: RTL and testbench
===================================

Name: key_entry_buffer

Overview:
- Sits directly downstream of the alarm clock controller.
- Consumes the controller's `shift` strobe and the keypad scan code, converts numeric-keypad scan codes to BCD, and holds the last four digits entered as HH:MM.
- The alarm register and the time-load path read its digit outputs when the controller asserts load_alarm or load_new_time.
- Also owns digit count, legality check of the entered time, and an inactivity auto-clear.

Parameters:
- TIMEOUT_SECONDS, 10, one_second pulses of inactivity, with at least one digit held, before the buffer self-clears (range 1-255).

Ports:
- clk256  input  1  256 Hz system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- one_second  input  1  one-clk256-cycle pulse, once per second.
- key  input  8  current keypad scan code (PS/2 numeric-pad set).
- shift  input  1  store strobe from the controller; may stay high more than one cycle.
- clear  input  1  synchronous clear request (level).
- ms_hour  output  4  BCD tens-of-hours digit.
- ls_hour  output  4  BCD units-of-hours digit.
- ms_minute  output  4  BCD tens-of-minutes digit.
- ls_minute  output  4  BCD units-of-minutes digit.
- digit_count  output  3  digits held, 0-4, saturating.
- time_valid  output  1  buffer holds a legal time.
- bad_key  output  1  one-cycle pulse: shift edge with a non-digit key.
- timed_out  output  1  one-cycle pulse: inactivity auto-clear occurred.

Behaviour:
- Reset (reset==0 at a clock edge): all digits 0, digit_count 0, bad_key 0, timed_out 0, internal timer 0, shift-edge register 0. Reset overrides every other input.
- Scan-code decode: 0x70→0, 0x69→1, 0x72→2, 0x7A→3, 0x6B→4, 0x73→5, 0x74→6, 0x6C→7, 0x75→8, 0x7D→9. Every other code is a non-digit.
- Store event = shift high this cycle and low the previous cycle (registered edge detect). One store per strobe regardless of pulse length.
- Store with a digit, 1 cycle latency:
  - ms_hour←ls_hour, ls_hour←ms_minute, ms_minute←ls_minute, ls_minute←digit.
  - digit_count increments, saturating at 4.
  - A fifth and later digit still shifts; the oldest digit is dropped.
  - Timer reloads to TIMEOUT_SECONDS.
- Store with a non-digit: digits, count and timer unchanged; bad_key=1 for exactly the next cycle.
- clear==1:
  - Digits 0, count 0, timer 0 on the next edge.
  - Has priority over a simultaneous store; the store is discarded and bad_key is not raised.
  - Does not assert timed_out.
- Inactivity timer:
  - Decrements on one_second only when digit_count>0 and timer>0.
  - A store and one_second in the same cycle: reload wins.
  - When a decrement takes timer from 1 to 0: digits and count clear on the same edge, and timed_out=1 for the following cycle.
  - Timer never wraps below 0.
- time_valid, combinational from registers:
  - Requires digit_count≥1, all digits ≤9, {ms_hour,ls_hour}≤23 and ms_minute≤5.
  - Digits are right-justified, so partial entry "930" reads as 09:30.
  - digit_count==0 forces time_valid=0.
- bad_key and timed_out default to 0 in every cycle where their condition is not met.

Test Plan:
- Reset then keys 0x69,0x72,0x73,0x7D (1,2,5,9), each with a 1-cycle shift → digits 1,2,5,9; digit_count=4; time_valid=1.
- shift held high 5 cycles with key=0x73 → exactly one store: ls_minute=5, digit_count=1, time_valid=1 (00:05).
- Key sequence 2,5,3,0 → 25:30, time_valid=0. A further 0x6C (7) → 5,3,0,7, digit_count stays 4, time_valid=0 because ms_minute=3 fails the ≤5 check? No: minutes "07" pass, hours "53" fail, so time_valid=0.
- shift edge with key=0x7C (star) → bad_key high exactly 1 cycle; digits and count unchanged. clear asserted together with a digit store → all zero, bad_key stays 0.
- TIMEOUT_SECONDS=10, one digit entered, then 10 one_second pulses → clears on the 10th pulse, timed_out 1 cycle. A digit entered coincident with the 9th pulse restarts the count, so no clear occurs.
- reset driven low mid-entry (digit_count=3, timer=4) for one edge → every output 0. A following one_second pulse produces no timed_out.

Source files
------------

// File: rtl/key_entry_buffer_if.sv
// rtl/key_entry_buffer_if.sv - keypad entry bus between controller side and key entry buffer
interface key_entry_if;
    logic [7:0] key;
    logic       shift;
    logic       clear;
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_minute;
    logic [3:0] ls_minute;
    logic [2:0] digit_count;
    logic       time_valid;
    logic       bad_key;
    logic       timed_out;

    modport master (
        output key, shift, clear,
        input  ms_hour, ls_hour, ms_minute, ls_minute,
        input  digit_count, time_valid, bad_key, timed_out
    );

    modport slave (
        input  key, shift, clear,
        output ms_hour, ls_hour, ms_minute, ls_minute,
        output digit_count, time_valid, bad_key, timed_out
    );
endinterface

// File: rtl/key_entry_buffer.sv
// rtl/key_entry_buffer.sv - four-digit HH:MM keypad entry shift buffer with legality check and idle auto-clear
module key_entry_buffer #(
    parameter int unsigned TIMEOUT_SECONDS = 10
) (
    input  logic       clk256,
    input  logic       reset,
    input  logic       one_second,
    key_entry_if.slave kbus
);
    localparam logic [7:0] TIMEOUT_RELOAD = 8'(TIMEOUT_SECONDS);

    logic [3:0] ms_hour_q, ms_hour_d;
    logic [3:0] ls_hour_q, ls_hour_d;
    logic [3:0] ms_minute_q, ms_minute_d;
    logic [3:0] ls_minute_q, ls_minute_d;
    logic [2:0] count_q, count_d;
    logic [7:0] timer_q, timer_d;
    logic       shift_q;
    logic       bad_key_q, bad_key_d;
    logic       timed_out_q, timed_out_d;

    logic       store;
    logic       is_digit;
    logic [3:0] digit;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (kbus.key)
            8'h70: digit = 4'd0;
            8'h69: digit = 4'd1;
            8'h72: digit = 4'd2;
            8'h7A: digit = 4'd3;
            8'h6B: digit = 4'd4;
            8'h73: digit = 4'd5;
            8'h74: digit = 4'd6;
            8'h6C: digit = 4'd7;
            8'h75: digit = 4'd8;
            8'h7D: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // A held strobe stores once: only the rising edge counts.
    assign store = kbus.shift && !shift_q;

    always_comb begin
        ms_hour_d   = ms_hour_q;
        ls_hour_d   = ls_hour_q;
        ms_minute_d = ms_minute_q;
        ls_minute_d = ls_minute_q;
        count_d     = count_q;
        timer_d     = timer_q;
        bad_key_d   = 1'b0;
        timed_out_d = 1'b0;

        if (kbus.clear) begin
            ms_hour_d   = 4'd0;
            ls_hour_d   = 4'd0;
            ms_minute_d = 4'd0;
            ls_minute_d = 4'd0;
            count_d     = 3'd0;
            timer_d     = 8'd0;
        end else if (store && is_digit) begin
            ms_hour_d   = ls_hour_q;
            ls_hour_d   = ms_minute_q;
            ms_minute_d = ls_minute_q;
            ls_minute_d = digit;
            count_d     = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
            timer_d     = TIMEOUT_RELOAD;
        end else if (store) begin
            bad_key_d = 1'b1;
        end else if (one_second && count_q != 3'd0 && timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
            if (timer_q == 8'd1) begin
                ms_hour_d   = 4'd0;
                ls_hour_d   = 4'd0;
                ms_minute_d = 4'd0;
                ls_minute_d = 4'd0;
                count_d     = 3'd0;
                timed_out_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk256) begin
        if (!reset) begin
            ms_hour_q   <= 4'd0;
            ls_hour_q   <= 4'd0;
            ms_minute_q <= 4'd0;
            ls_minute_q <= 4'd0;
            count_q     <= 3'd0;
            timer_q     <= 8'd0;
            shift_q     <= 1'b0;
            bad_key_q   <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            ms_hour_q   <= ms_hour_d;
            ls_hour_q   <= ls_hour_d;
            ms_minute_q <= ms_minute_d;
            ls_minute_q <= ls_minute_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            shift_q     <= kbus.shift;
            bad_key_q   <= bad_key_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Right-justified digits: hours legal up to 23, tens of minutes up to 5.
    logic digits_bcd;
    logic hours_ok;
    assign digits_bcd = (ms_hour_q <= 4'd9) && (ls_hour_q <= 4'd9) &&
                        (ms_minute_q <= 4'd9) && (ls_minute_q <= 4'd9);
    assign hours_ok   = (ms_hour_q < 4'd2) || (ms_hour_q == 4'd2 && ls_hour_q <= 4'd3);

    assign kbus.time_valid  = (count_q != 3'd0) && digits_bcd && hours_ok &&
                              (ms_minute_q <= 4'd5);
    assign kbus.ms_hour     = ms_hour_q;
    assign kbus.ls_hour     = ls_hour_q;
    assign kbus.ms_minute   = ms_minute_q;
    assign kbus.ls_minute   = ls_minute_q;
    assign kbus.digit_count = count_q;
    assign kbus.bad_key     = bad_key_q;
    assign kbus.timed_out   = timed_out_q;
endmodule

// File: tb/tb_key_entry_buffer.sv
// tb/tb_key_entry_buffer.sv - scoreboard bench for key_entry_buffer
module tb_key_entry_buffer;
    logic clk = 1'b0;
    logic reset_n;
    logic one_second;

    key_entry_if kbus ();

    key_entry_buffer #(.TIMEOUT_SECONDS(10)) dut (
        .clk256     (clk),
        .reset      (reset_n),
        .one_second (one_second),
        .kbus       (kbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mh, lh, mm, lm;
        logic [2:0] cnt;
        logic       tv, bk, to;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_s(input logic [3:0] mh, lh, mm, lm, input logic [2:0] cnt,
                            input logic tv, bk, to, input string nm);
        exp_t x;
        x.mh = mh; x.lh = lh; x.mm = mm; x.lm = lm;
        x.cnt = cnt; x.tv = tv; x.bk = bk; x.to = to; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic press(input logic [7:0] code);
        kbus.key   = code;
        kbus.shift = 1'b1;
        step();
        kbus.shift = 1'b0;
        step();
    endtask

    task automatic pulse();
        one_second = 1'b1;
        step();
        one_second = 1'b0;
    endtask

    task automatic do_clear();
        kbus.clear = 1'b1;
        step();
        kbus.clear = 1'b0;
    endtask

    // Monitor: outputs are registered, so mid-cycle is a stable sampling point.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if ({kbus.ms_hour, kbus.ls_hour, kbus.ms_minute, kbus.ls_minute, kbus.digit_count,
                 kbus.time_valid, kbus.bad_key, kbus.timed_out} !==
                {e.mh, e.lh, e.mm, e.lm, e.cnt, e.tv, e.bk, e.to}) begin
                mismatched++;
                $display("FAIL %s: got %h%h:%h%h cnt=%0d tv=%b bk=%b to=%b, want %h%h:%h%h cnt=%0d tv=%b bk=%b to=%b",
                         e.name, kbus.ms_hour, kbus.ls_hour, kbus.ms_minute, kbus.ls_minute,
                         kbus.digit_count, kbus.time_valid, kbus.bad_key, kbus.timed_out,
                         e.mh, e.lh, e.mm, e.lm, e.cnt, e.tv, e.bk, e.to);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        one_second = 1'b0;
        kbus.key   = 8'h00;
        kbus.shift = 1'b0;
        kbus.clear = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        expect_s(0, 0, 0, 0, 0, 0, 0, 0, "reset");

        press(8'h69);
        expect_s(0, 0, 0, 1, 1, 1, 0, 0, "first_digit");
        press(8'h72);
        press(8'h73);
        press(8'h7D);
        expect_s(1, 2, 5, 9, 4, 1, 0, 0, "entry_1259");

        do_clear();
        expect_s(0, 0, 0, 0, 0, 0, 0, 0, "clear");
        kbus.key   = 8'h73;
        kbus.shift = 1'b1;
        step();
        expect_s(0, 0, 0, 5, 1, 1, 0, 0, "held_shift_first");
        for (int i = 0; i < 4; i++) step();
        expect_s(0, 0, 0, 5, 1, 1, 0, 0, "held_shift_once");
        kbus.shift = 1'b0;
        step();

        do_clear();
        press(8'h72);
        press(8'h6B - 8'h6B + 8'h73);
        press(8'h7A);
        press(8'h70);
        expect_s(2, 5, 3, 0, 4, 0, 0, 0, "hours_25");
        press(8'h6C);
        expect_s(5, 3, 0, 7, 4, 0, 0, 0, "fifth_digit");

        do_clear();
        press(8'h72);
        press(8'h7A);
        press(8'h73);
        press(8'h7D);
        expect_s(2, 3, 5, 9, 4, 1, 0, 0, "max_2359");
        do_clear();
        press(8'h69);
        press(8'h72);
        press(8'h74);
        press(8'h70);
        expect_s(1, 2, 6, 0, 4, 0, 0, 0, "minutes_60");

        kbus.key   = 8'h7C;
        kbus.shift = 1'b1;
        step();
        expect_s(1, 2, 6, 0, 4, 0, 1, 0, "bad_key_pulse");
        kbus.shift = 1'b0;
        step();
        expect_s(1, 2, 6, 0, 4, 0, 0, 0, "bad_key_one_cycle");

        kbus.key   = 8'h75;
        kbus.shift = 1'b1;
        kbus.clear = 1'b1;
        step();
        expect_s(0, 0, 0, 0, 0, 0, 0, 0, "clear_beats_store");
        kbus.shift = 1'b0;
        kbus.clear = 1'b0;
        step();
        expect_s(0, 0, 0, 0, 0, 0, 0, 0, "clear_no_bad_key");

        press(8'h69);
        for (int i = 0; i < 9; i++) pulse();
        expect_s(0, 0, 0, 1, 1, 1, 0, 0, "nine_pulses_held");
        pulse();
        expect_s(0, 0, 0, 0, 0, 0, 0, 1, "timeout_clear");
        step();
        expect_s(0, 0, 0, 0, 0, 0, 0, 0, "timeout_one_cycle");

        press(8'h69);
        for (int i = 0; i < 8; i++) pulse();
        kbus.key   = 8'h72;
        kbus.shift = 1'b1;
        one_second = 1'b1;
        step();
        kbus.shift = 1'b0;
        one_second = 1'b0;
        expect_s(0, 0, 1, 2, 2, 1, 0, 0, "store_with_pulse");
        for (int i = 0; i < 9; i++) pulse();
        expect_s(0, 0, 1, 2, 2, 1, 0, 0, "reload_no_clear");
        pulse();
        expect_s(0, 0, 0, 0, 0, 0, 0, 1, "reload_then_timeout");

        do_clear();
        press(8'h69);
        press(8'h72);
        press(8'h7A);
        for (int i = 0; i < 6; i++) pulse();
        expect_s(0, 1, 2, 3, 3, 1, 0, 0, "pre_reset_entry");
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        expect_s(0, 0, 0, 0, 0, 0, 0, 0, "mid_entry_reset");
        pulse();
        expect_s(0, 0, 0, 0, 0, 0, 0, 0, "pulse_after_reset");

        step();
        step();
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
